// File: rtl/tube_xfer_fifo_if.sv
// Push/pop handshake bundle for the Tube transfer FIFO.
// The master side drives requests; the slave side (the FIFO) returns data and fill flags.
interface tube_xfer_fifo_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty
    );
endinterface

// File: rtl/tube_xfer_fifo.sv
// Tube-style transfer FIFO: DEPTH-entry store with wrap-bit pointers, registered pop data,
// programmable availability threshold, active-low interrupt and sticky overflow/underflow flags.
module tube_xfer_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int STATUS_FILL = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                h_rst_b,
    input  logic                soft_rst,
    tube_xfer_fifo_if.slave     bus,
    input  logic [AW:0]         thr,
    input  logic                irq_en,
    input  logic                clr_err,
    output logic [AW:0]         level,
    output logic                avail,
    output logic [WIDTH-1:0]    status,
    output logic                irq_b,
    output logic                ovf,
    output logic                udf
);

    localparam logic [AW:0]        DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [WIDTH-3:0]   FILL_BITS = (WIDTH-2)'(STATUS_FILL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]      wptr_reg, wptr_next;
    logic [AW:0]      rptr_reg, rptr_next;
    logic [WIDTH-1:0] rd_data_reg, rd_data_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;

    logic             full_w, empty_w;
    logic             push_ok, pop_ok, ovf_evt, udf_evt;
    logic [AW:0]      eff_thr;

    // Pointer difference modulo 2*DEPTH yields 0..DEPTH thanks to the extra wrap bit.
    assign level   = wptr_reg - rptr_reg;
    assign full_w  = (level == DEPTH_W);
    assign empty_w = (level == '0);

    assign eff_thr = (thr == '0)     ? (AW+1)'(1) :
                     (thr > DEPTH_W) ? DEPTH_W    : thr;
    assign avail   = (level >= eff_thr);
    assign irq_b   = !(irq_en && avail);
    assign status  = {avail, !full_w, FILL_BITS};

    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.rd_data = rd_data_reg;
    assign ovf         = ovf_reg;
    assign udf         = udf_reg;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign pop_ok  = bus.rd_en && !empty_w;
    assign push_ok = bus.wr_en && (!full_w || bus.rd_en);
    assign ovf_evt = bus.wr_en && full_w && !bus.rd_en;
    assign udf_evt = bus.rd_en && empty_w;

    always_comb begin
        wptr_next    = wptr_reg;
        rptr_next    = rptr_reg;
        rd_data_next = rd_data_reg;
        ovf_next     = ovf_reg;
        udf_next     = udf_reg;
        if (soft_rst) begin
            wptr_next    = '0;
            rptr_next    = '0;
            rd_data_next = '0;
            ovf_next     = 1'b0;
            udf_next     = 1'b0;
        end else begin
            if (push_ok) wptr_next = wptr_reg + 1'b1;
            if (pop_ok) begin
                rptr_next    = rptr_reg + 1'b1;
                rd_data_next = mem[rptr_reg[AW-1:0]];
            end
            // A new error in the clearing cycle keeps its flag set.
            ovf_next = ovf_evt || (ovf_reg && !clr_err);
            udf_next = udf_evt || (udf_reg && !clr_err);
        end
    end

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            rd_data_reg <= '0;
            ovf_reg     <= 1'b0;
            udf_reg     <= 1'b0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            rd_data_reg <= rd_data_next;
            ovf_reg     <= ovf_next;
            udf_reg     <= udf_next;
        end
    end

    // Storage is never reset; entries are unobservable until written.
    always_ff @(posedge clk) begin
        if (!soft_rst && push_ok && h_rst_b)
            mem[wptr_reg[AW-1:0]] <= bus.wr_data;
    end

endmodule

// File: doc/tube_xfer_fifo.md
TUBE_XFER_FIFO -- requirements
Module: tube_xfer_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of 2, minimum 2; AW = log2(DEPTH).
REQ-003 SHALL have parameter STATUS_FILL, default 1, value driven on status bits [WIDTH-3:0].
REQ-004 SHALL have port clk, input, 1 bit, single system clock; all state updates on rising edge.
REQ-005 SHALL have port h_rst_b, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port soft_rst, input, 1 bit, synchronous flush (Tube T flag).
REQ-007 SHALL have port wr_en, input, 1 bit, push request from writing side.
REQ-008 SHALL have port wr_data, input, WIDTH bits, push data.
REQ-009 SHALL have port rd_en, input, 1 bit, pop request from reading side.
REQ-010 SHALL have port rd_data, output, WIDTH bits, registered popped word.
REQ-011 SHALL have port thr, input, AW+1 bits, availability threshold in words; generalises one-/two-byte mode.
REQ-012 SHALL have port irq_en, input, 1 bit, interrupt enable (Tube I/J/Q/M flag).
REQ-013 SHALL have port clr_err, input, 1 bit, clears sticky error flags.
REQ-014 SHALL have port level, output, AW+1 bits, current occupancy 0..DEPTH.
REQ-015 SHALL have port full, output, 1 bit, level == DEPTH.
REQ-016 SHALL have port empty, output, 1 bit, level == 0.
REQ-017 SHALL have port avail, output, 1 bit, level >= effective threshold.
REQ-018 SHALL have port status, output, WIDTH bits, {avail, !full, STATUS_FILL bits}.
REQ-019 SHALL have port irq_b, output, 1 bit, active-low interrupt, driven 0 or 1.
REQ-020 SHALL have ports ovf and udf, output, 1 bit each, sticky overflow/underflow flags.

Function
REQ-021 SHALL store words in a DEPTH-entry array with AW+1-bit write and read pointers; MSB distinguishes full from empty on wrap.
REQ-022 SHALL accept a push when wr_en=1 and full=0: store wr_data at wptr, increment wptr modulo 2*DEPTH.
REQ-023 SHALL discard a push when wr_en=1 and full=1: array and wptr unchanged, ovf set next cycle.
REQ-024 SHALL perform a pop when rd_en=1 and empty=0: rd_data <= entry at rptr, increment rptr, one-cycle latency.
REQ-025 SHALL treat a pop when empty=1 as underflow: rd_data holds previous value, rptr unchanged, udf set.
REQ-026 SHALL, on simultaneous push and pop while full, perform both; level stays DEPTH, ovf not set.
REQ-027 SHALL, on simultaneous push and pop while empty, complete the push only; no bypass; udf set; level becomes 1.
REQ-028 SHALL make a pushed word visible to level/avail/empty on the cycle after the push edge.
REQ-029 SHALL use effective threshold = 1 when thr==0, DEPTH when thr>DEPTH, else thr.
REQ-030 SHALL derive level, full, empty, avail, status and irq_b combinationally from the registered pointers and current thr/irq_en.
REQ-031 SHALL drive irq_b = !(irq_en & avail).
REQ-032 SHALL clear ovf and udf on clr_err=1; a new error in the same cycle as clr_err sets the flag (set wins).
REQ-033 SHALL, on soft_rst=1, zero both pointers, rd_data and ovf/udf at the next edge; soft_rst overrides wr_en/rd_en that cycle.

Reset
REQ-034 SHALL, while h_rst_b=0, force wptr=0, rptr=0, rd_data=0, ovf=0, udf=0 regardless of clk.
REQ-035 SHALL present after reset: level=0, empty=1, full=0, avail=0, irq_b=1, status={0,1,STATUS_FILL bits}.
REQ-036 SHALL not reset array contents; contents are unobservable until written.
REQ-037 SHALL abort any in-progress traffic on reset assertion mid-operation; the first push after release lands at index 0.

Verification
REQ-038 Reset, then push 0xA5 with thr=1, irq_en=1 -> next cycle level=1, avail=1, irq_b=0, status[7:6]=2'b11.
REQ-039 Defaults, thr=2: push 0x11 -> avail=0; push 0x22 -> avail=1; pop twice -> rd_data 0x11 then 0x22, empty=1.
REQ-040 DEPTH=4: push 5 words 0x01..0x05 -> full=1, ovf=1, status[6]=0; pop 4 -> 0x01..0x04; 0x05 lost.
REQ-041 Full FIFO: push and pop in one cycle -> level stays 4, ovf=0; repeat 8 times so pointers wrap; data order intact.
REQ-042 Empty: pop -> udf=1, rd_data unchanged; clr_err with a new pop same cycle -> udf stays 1.
REQ-043 Level 3: assert soft_rst with wr_en=1 -> level=0, ovf=udf=0; pulse h_rst_b low between clk edges -> outputs at reset values immediately.
